// File: rtl/byte_stacker_if.sv
// byte_stacker_if: stream-in / block-out handshake bundle for byte_stacker.
//   slave  modport (packer side): consumes enable_i, flush_i, valid_i, word_i, ready_i;
//                                 drives ready_o, valid_o, word_o, lanes_o.
//   master modport (user side)  : the mirror image.
// Signal suffixes are named from the packer's point of view.
interface byte_stacker_if #(
    parameter int unsigned N_WORDS = 4
);
    localparam int unsigned LaneW = $clog2(N_WORDS + 1);

    logic                   enable_i;
    logic                   flush_i;
    logic                   valid_i;
    logic [31:0]            word_i;
    logic                   ready_o;
    logic                   valid_o;
    logic                   ready_i;
    logic [32*N_WORDS-1:0]  word_o;
    logic [LaneW-1:0]       lanes_o;

    modport slave (
        input  enable_i, flush_i, valid_i, word_i, ready_i,
        output ready_o, valid_o, word_o, lanes_o
    );

    modport master (
        output enable_i, flush_i, valid_i, word_i, ready_i,
        input  ready_o, valid_o, word_o, lanes_o
    );
endinterface

// File: rtl/byte_stacker.sv
// byte_stacker: packs N_WORDS consecutive 32-bit words into one block, first word in the
// most-significant lane. One-entry output register so packing overlaps with draining.
// A flush emits a zero-padded partial block together with its valid lane count.
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - synchronous active-high reset
//   clr_i  - synchronous soft clear (same effect as rst_i, lower priority)
//   bus    - byte_stacker_if.slave: input stream, flush request, output block handshake
module byte_stacker #(
    parameter int unsigned N_WORDS = 4
) (
    input logic            clk_i,
    input logic            rst_i,
    input logic            clr_i,
    byte_stacker_if.slave  bus
);
    localparam int unsigned CntW  = $clog2(N_WORDS);
    localparam int unsigned LaneW = $clog2(N_WORDS + 1);
    localparam int unsigned BlkW  = 32 * N_WORDS;

    logic [BlkW-1:0]  acc_r;
    logic [CntW-1:0]  cnt_r;
    logic [BlkW-1:0]  out_r;
    logic [LaneW-1:0] lanes_r;
    logic             valid_r;

    logic             any_reset;
    logic             slot_free;
    logic             last_lane;
    logic             ready;
    logic             accept;
    logic [LaneW-1:0] fill;
    logic             full_emit;
    logic             flush_emit;
    logic [BlkW-1:0]  acc_wr;
    logic [BlkW-1:0]  emit_blk;

    assign any_reset = rst_i | clr_i;
    // Combinational on ready_i so a full accumulator can hand off in the drain cycle.
    assign slot_free = ~valid_r | bus.ready_i;
    assign last_lane = (cnt_r == CntW'(N_WORDS - 1));
    assign ready     = bus.enable_i & (~last_lane | slot_free) & ~any_reset;
    assign accept    = bus.valid_i & ready;
    // Lanes filled once this cycle's word (if any) is counted; equals N_WORDS on a full block.
    assign fill       = LaneW'(cnt_r) + LaneW'(accept);
    assign full_emit  = accept & last_lane;
    assign flush_emit = bus.flush_i & slot_free & (fill != '0) & ~full_emit;

    // Accumulator image with this cycle's word placed in lane cnt_r.
    always_comb begin
        acc_wr = acc_r;
        for (int k = 0; k < int'(N_WORDS); k++) begin
            if (accept && cnt_r == CntW'(k)) begin
                acc_wr[32*(int'(N_WORDS)-k)-1 -: 32] = bus.word_i;
            end
        end
    end

    // Lanes at or beyond the fill count are forced to zero on emission.
    always_comb begin
        emit_blk = acc_wr;
        for (int k = 0; k < int'(N_WORDS); k++) begin
            if (k >= int'(fill)) begin
                emit_blk[32*(int'(N_WORDS)-k)-1 -: 32] = '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (any_reset) begin
            acc_r   <= '0;
            cnt_r   <= '0;
            out_r   <= '0;
            lanes_r <= '0;
            valid_r <= 1'b0;
        end else if (full_emit || flush_emit) begin
            // Emission only fires with a free slot, so it safely overwrites any draining block.
            out_r   <= emit_blk;
            lanes_r <= fill;
            valid_r <= 1'b1;
            acc_r   <= '0;
            cnt_r   <= '0;
        end else begin
            if (accept) begin
                acc_r <= acc_wr;
                cnt_r <= cnt_r + CntW'(1);
            end
            if (valid_r && bus.ready_i) begin
                out_r   <= '0;
                lanes_r <= '0;
                valid_r <= 1'b0;
            end
        end
    end

    assign bus.ready_o = ready;
    assign bus.valid_o = valid_r;
    assign bus.word_o  = out_r;
    assign bus.lanes_o = lanes_r;
endmodule

// File: tb/tb_byte_stacker.sv
module tb_byte_stacker;
    localparam int unsigned N = 4;

    logic clk;
    logic rst;
    logic clr;
    int   errors;
    int   checks;

    byte_stacker_if #(.N_WORDS(N)) bus ();

    byte_stacker #(.N_WORDS(N)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (clr),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] w);
        bus.valid_i = 1'b1;
        bus.word_i  = w;
        tick();
        bus.valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.enable_i = 1'b1;
        bus.valid_i  = 1'b1;
        #1;
        checks++;
        if (bus.ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_low: got %b want 0", bus.ready_o);
        end
        tick();
        tick();
        bus.valid_i = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b want 0", bus.valid_o);
        end
        checks++;
        if (bus.word_o !== 128'h0) begin
            errors++;
            $display("FAIL reset_word: got %h want 0", bus.word_o);
        end
        checks++;
        if (bus.lanes_o !== 3'd0) begin
            errors++;
            $display("FAIL reset_lanes: got %0d want 0", bus.lanes_o);
        end
        checks++;
        if (bus.ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_after: got %b want 1", bus.ready_o);
        end
    endtask

    task automatic test_basic_pack();
        bus.ready_i = 1'b1;
        put(32'h1);
        put(32'h2);
        put(32'h3);
        checks++;
        if (bus.valid_o !== 1'b0) begin
            errors++;
            $display("FAIL pack_early_valid: got %b want 0", bus.valid_o);
        end
        put(32'h4);
        checks++;
        if (bus.valid_o !== 1'b1 || bus.lanes_o !== 3'd4 ||
            bus.word_o !== 128'h00000001_00000002_00000003_00000004) begin
            errors++;
            $display("FAIL pack_block: got v=%b l=%0d w=%h want v=1 l=4 w=%h", bus.valid_o,
                     bus.lanes_o, bus.word_o, 128'h00000001_00000002_00000003_00000004);
        end
        tick();
        checks++;
        if (bus.valid_o !== 1'b0 || bus.word_o !== 128'h0 || bus.lanes_o !== 3'd0) begin
            errors++;
            $display("FAIL pack_drain: got v=%b l=%0d w=%h want all 0", bus.valid_o,
                     bus.lanes_o, bus.word_o);
        end
    endtask

    task automatic test_backpressure();
        bus.ready_i = 1'b0;
        for (int i = 0; i < 4; i++) put(32'hA0 + i);
        checks++;
        if (bus.valid_o !== 1'b1 || bus.word_o !== 128'hA0_000000A1_000000A2_000000A3) begin
            errors++;
            $display("FAIL bp_first_block: got v=%b w=%h", bus.valid_o, bus.word_o);
        end
        for (int i = 4; i < 7; i++) begin
            bus.valid_i = 1'b1;
            bus.word_i  = 32'hA0 + i;
            #1;
            checks++;
            if (bus.ready_o !== 1'b1) begin
                errors++;
                $display("FAIL bp_ready_fill%0d: got %b want 1", i, bus.ready_o);
            end
            tick();
        end
        bus.valid_i = 1'b1;
        bus.word_i  = 32'hA7;
        #1;
        checks++;
        if (bus.ready_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_ready_full: got %b want 0", bus.ready_o);
        end
        tick();
        tick();
        checks++;
        if (bus.valid_o !== 1'b1 || bus.word_o !== 128'hA0_000000A1_000000A2_000000A3 ||
            bus.lanes_o !== 3'd4) begin
            errors++;
            $display("FAIL bp_stable: got v=%b l=%0d w=%h", bus.valid_o, bus.lanes_o,
                     bus.word_o);
        end
        bus.ready_i = 1'b1;
        #1;
        checks++;
        if (bus.ready_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_release: got %b want 1", bus.ready_o);
        end
        tick();
        bus.valid_i = 1'b0;
        checks++;
        if (bus.valid_o !== 1'b1 || bus.word_o !== 128'hA4_000000A5_000000A6_000000A7 ||
            bus.lanes_o !== 3'd4) begin
            errors++;
            $display("FAIL bp_second_block: got v=%b l=%0d w=%h want %h", bus.valid_o,
                     bus.lanes_o, bus.word_o, 128'hA4_000000A5_000000A6_000000A7);
        end
        tick();
        checks++;
        if (bus.valid_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: got %b want 0", bus.valid_o);
        end
    endtask

    task automatic test_flush_partial();
        bus.ready_i = 1'b1;
        put(32'h11111111);
        put(32'h22222222);
        bus.flush_i = 1'b1;
        tick();
        checks++;
        if (bus.valid_o !== 1'b1 || bus.lanes_o !== 3'd2 ||
            bus.word_o !== 128'h11111111_22222222_00000000_00000000) begin
            errors++;
            $display("FAIL flush_partial: got v=%b l=%0d w=%h", bus.valid_o, bus.lanes_o,
                     bus.word_o);
        end
        tick();
        tick();
        checks++;
        if (bus.valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_empty: got %b want 0", bus.valid_o);
        end
        bus.flush_i = 1'b0;
    endtask

    task automatic test_flush_coincident();
        bus.ready_i = 1'b1;
        put(32'h31);
        put(32'h32);
        bus.flush_i = 1'b1;
        put(32'h33);
        bus.flush_i = 1'b0;
        checks++;
        if (bus.valid_o !== 1'b1 || bus.lanes_o !== 3'd3 ||
            bus.word_o !== 128'h31_00000032_00000033_00000000) begin
            errors++;
            $display("FAIL flush_coinc3: got v=%b l=%0d w=%h", bus.valid_o, bus.lanes_o,
                     bus.word_o);
        end
        tick();
        put(32'h41);
        put(32'h42);
        put(32'h43);
        bus.flush_i = 1'b1;
        put(32'h44);
        bus.flush_i = 1'b0;
        checks++;
        if (bus.valid_o !== 1'b1 || bus.lanes_o !== 3'd4 ||
            bus.word_o !== 128'h41_00000042_00000043_00000044) begin
            errors++;
            $display("FAIL flush_coinc4: got v=%b l=%0d w=%h", bus.valid_o, bus.lanes_o,
                     bus.word_o);
        end
        tick();
    endtask

    task automatic test_clear();
        bus.ready_i = 1'b0;
        for (int i = 0; i < 4; i++) put(32'h50 + i);
        put(32'h54);
        put(32'h55);
        clr = 1'b1;
        bus.valid_i = 1'b1;
        bus.word_i  = 32'h56;
        #1;
        checks++;
        if (bus.ready_o !== 1'b0) begin
            errors++;
            $display("FAIL clr_ready: got %b want 0", bus.ready_o);
        end
        tick();
        clr = 1'b0;
        bus.valid_i = 1'b0;
        checks++;
        if (bus.valid_o !== 1'b0 || bus.word_o !== 128'h0 || bus.lanes_o !== 3'd0) begin
            errors++;
            $display("FAIL clr_out: got v=%b l=%0d w=%h want all 0", bus.valid_o,
                     bus.lanes_o, bus.word_o);
        end
        bus.ready_i = 1'b1;
        for (int i = 1; i < 5; i++) put(32'h60 + i);
        checks++;
        if (bus.valid_o !== 1'b1 || bus.lanes_o !== 3'd4 ||
            bus.word_o !== 128'h61_00000062_00000063_00000064) begin
            errors++;
            $display("FAIL clr_next_block: got v=%b l=%0d w=%h", bus.valid_o, bus.lanes_o,
                     bus.word_o);
        end
        tick();
    endtask

    task automatic test_enable();
        bus.ready_i = 1'b0;
        for (int i = 1; i < 5; i++) put(32'h70 + i);
        put(32'h75);
        bus.enable_i = 1'b0;
        bus.valid_i  = 1'b1;
        bus.word_i   = 32'h99;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (bus.ready_o !== 1'b0) begin
                errors++;
                $display("FAIL en_ready_c%0d: got %b want 0", i, bus.ready_o);
            end
            tick();
        end
        bus.ready_i = 1'b1;
        tick();
        bus.valid_i = 1'b0;
        checks++;
        if (bus.valid_o !== 1'b0) begin
            errors++;
            $display("FAIL en_drain: got %b want 0", bus.valid_o);
        end
        bus.enable_i = 1'b1;
        put(32'h76);
        put(32'h77);
        put(32'h78);
        checks++;
        if (bus.valid_o !== 1'b1 || bus.lanes_o !== 3'd4 ||
            bus.word_o !== 128'h75_00000076_00000077_00000078) begin
            errors++;
            $display("FAIL en_held_cnt: got v=%b l=%0d w=%h", bus.valid_o, bus.lanes_o,
                     bus.word_o);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        bus.ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.valid_i = 1'b1;
            bus.word_i  = 32'h81 + i;
            #1;
            checks++;
            if (bus.ready_o !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready%0d: got %b want 1", i, bus.ready_o);
            end
            tick();
            checks++;
            if (bus.valid_o !== (i == 3 || i == 7)) begin
                errors++;
                $display("FAIL b2b_valid%0d: got %b", i, bus.valid_o);
            end
            if (i == 7) begin
                checks++;
                if (bus.word_o !== 128'h85_00000086_00000087_00000088) begin
                    errors++;
                    $display("FAIL b2b_block2: got %h", bus.word_o);
                end
            end
        end
        bus.valid_i = 1'b0;
        tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        clr = 1'b0;
        bus.enable_i = 1'b0;
        bus.flush_i  = 1'b0;
        bus.valid_i  = 1'b0;
        bus.word_i   = 32'h0;
        bus.ready_i  = 1'b0;
        test_reset();
        test_basic_pack();
        test_backpressure();
        test_flush_partial();
        test_flush_coincident();
        test_clear();
        test_enable();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
